ddr_rd_dma: RTL and testbench
=============================

DDR_RD_DMA -- requirements
Module: ddr_rd_dma

Interface
REQ-001 Parameter ADDR_W, default 40, AXI byte-address width.
REQ-002 Parameter DATA_W, default 256, AXI read data and stream width; bytes per beat are DATA_W/8 (32).
REQ-003 Parameter ID_W, default 4, AXI ID width.
REQ-004 Parameter MAX_BURST, default 16, maximum beats per AR burst, a power of two no greater than 256.
REQ-005 Port ps_clk, input, 1 bit: the single clock for all logic.
REQ-006 Port ps_rstb, input, 1 bit: asynchronous active-low reset.
REQ-007 Port pl_m_axi_rd, master side, AXI4 #(ID_W, ADDR_W, DATA_W) interface: read master into DDR4.
REQ-008 Port calib_done, input, 1 bit: DDR4 calibration complete, synchronous to ps_clk.
REQ-009 Port start, input, 1 bit: single-cycle request to begin a transfer.
REQ-010 Port base_addr, input, ADDR_W bits: first byte address, 32-byte aligned.
REQ-011 Port len_beats, input, 24 bits: total beats to read.
REQ-012 Port abort, input, 1 bit: single-cycle request to stop the transfer early.
REQ-013 Ports m_axis_tdata (output, DATA_W), m_axis_tvalid (output, 1), m_axis_tlast (output, 1) and m_axis_tready (input, 1): output stream toward the DAC path.
REQ-014 Ports busy, done, rd_err and aborted, all outputs, 1 bit: status signals.

Function
REQ-015 The block SHALL use the states IDLE, WAIT_CAL, ADDR, DATA and FIN.
REQ-016 From IDLE, start SHALL capture base_addr and len_beats; the block SHALL go to FIN if len_beats==0, else to WAIT_CAL if calib_done==0, else to ADDR.
REQ-017 The block SHALL ignore start in every state other than IDLE.
REQ-018 WAIT_CAL SHALL move to ADDR on the first cycle calib_done==1.
REQ-019 In ADDR, arvalid SHALL be 1, with arlen = burst-1, arsize=5, arburst=INCR, arid=0, arcache=4'b0011, arprot, arlock and arqos 0.
REQ-020 Burst length SHALL be min(remaining beats, MAX_BURST, beats to the next 4 KB boundary), where beats to boundary = (4096 - addr[11:0])/32.
REQ-021 AR signals SHALL hold stable while arvalid is high and arready is low.
REQ-022 On arvalid&&arready, the address SHALL advance by burst*32 and the state SHALL go to DATA.
REQ-023 Only one burst SHALL be outstanding at a time.
REQ-024 In DATA, the stream SHALL pass through with zero latency: m_axis_tvalid = rvalid, rready = m_axis_tready, and tdata = rdata.
REQ-025 Each accepted beat SHALL decrement the remaining count.
REQ-026 m_axis_tlast SHALL be 1 only on the final beat of the whole transfer, or the final beat of the draining burst after an abort.
REQ-027 On rvalid&&rready&&rlast, the block SHALL go to FIN if the remaining count is 0 or an abort is pending, else to ADDR.
REQ-028 If rresp is not 0, rd_err SHALL be set and remain set until the next accepted start; the beat is still forwarded.
REQ-029 abort in WAIT_CAL or ADDR-before-handshake SHALL go directly to FIN with aborted=1.
REQ-030 abort in ADDR after the handshake, or in DATA, SHALL drain the current burst completely, then go to FIN with aborted=1.
REQ-031 An abort and a start in the same IDLE cycle SHALL be treated as a start only.
REQ-032 FIN SHALL last one cycle: done=1, then the state returns to IDLE.
REQ-033 busy SHALL be 1 in every state other than IDLE.
REQ-034 AXI write channels SHALL be held inactive (awvalid=0, wvalid=0, bready=1, all other write signals 0).
REQ-035 rready SHALL be 0 outside DATA.

Reset
REQ-036 On ps_rstb low, the state SHALL be IDLE and arvalid, rready, m_axis_tvalid, m_axis_tlast, busy, done, rd_err and aborted SHALL all be 0.
REQ-037 On ps_rstb low, the address and counters SHALL be 0.
REQ-038 A reset during an outstanding burst SHALL abandon it; the system resets the interconnect alongside this block.

Structure
REQ-039 A shared package, dma_pkg, SHALL hold the state enum, BYTES_PER_BEAT, the 4 KB boundary constant and the AXI burst/size encodings.
REQ-040 The burst-length computation SHALL live in one combinational sub-module, dma_burst_calc.

Verification
REQ-041 base=0x0, len=40, MAX_BURST=16, tready=1 -> ARs with arlen 15, 15, 7 at addresses 0x0, 0x200, 0x400; 40 beats; tlast on beat 40; done pulses once.
REQ-042 base=0xFC0, len=4 -> ARs of 2 beats at 0xFC0 and 2 beats at 0x1000 (no 4 KB crossing).
REQ-043 len=0 -> no arvalid; done and not busy two cycles after start.
REQ-044 calib_done held 0 for 50 cycles after start -> no arvalid until calib_done rises; the transfer then completes normally.
REQ-045 abort in mid DATA of a len=64 transfer -> the current 16-beat burst completes, tlast on its last beat, no further AR, done=1 and aborted=1.
REQ-046 rresp=SLVERR on one beat with random tready stalls -> all beats delivered in order with no duplicates, rd_err=1 sticky, cleared by the next start.

Source files
------------

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Brief    : Shared states and AXI constants for the DDR read DMA.
// Revision : 1.0
// ============================================================================
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_CAL = 3'd1,
        ADDR     = 3'd2,
        DATA     = 3'd3,
        FIN      = 3'd4
    } dma_state_t;

    localparam int         BYTES_PER_BEAT   = 32;
    localparam int         c_BOUNDARY_4K    = 4096;
    localparam logic [2:0] c_AXI_SIZE_32B   = 3'd5;
    localparam logic [1:0] c_AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] c_AXI_CACHE_RD   = 4'b0011;

endpackage
`default_nettype wire

// File: rtl/axi4_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_if
// Brief    : AXI4 full interface bundle with master and slave views.
// Revision : 1.0
// ============================================================================
interface axi4_if #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 40,
    parameter int DATA_W = 256
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;
    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output rready,
        input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  rready,
        output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/dma_burst_calc.sv
`default_nettype none
// ============================================================================
// Module   : dma_burst_calc
// Brief    : Beats for the next AR: min(remaining, MAX_BURST, beats to 4 KB page end).
// Revision : 1.0
// ============================================================================
module dma_burst_calc
    import dma_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [6:0]  i_beat_in_page,
    input  logic [23:0] i_remain,
    output logic [8:0]  o_burst
);

    logic [8:0] w_to_bound;
    logic [8:0] w_cap;
    logic [8:0] w_lim;

    // Addresses are beat aligned, so the page offset in beats is addr[11:5].
    assign w_to_bound = 9'(c_BOUNDARY_4K / BYTES_PER_BEAT) - {2'b00, i_beat_in_page};
    assign w_cap      = 9'(MAX_BURST);
    assign w_lim      = (w_to_bound < w_cap) ? w_to_bound : w_cap;
    assign o_burst    = (i_remain < 24'(w_lim)) ? i_remain[8:0] : w_lim;

endmodule
`default_nettype wire

// File: rtl/ddr_rd_dma.sv
`default_nettype none
// ============================================================================
// Module   : ddr_rd_dma
// Brief    : Single-outstanding AXI4 burst reader from DDR4 into a stream port.
// Revision : 1.0
// ============================================================================
module ddr_rd_dma
    import dma_pkg::*;
#(
    parameter int ADDR_W    = 40,
    parameter int DATA_W    = 256,
    parameter int ID_W      = 4,
    parameter int MAX_BURST = 16
) (
    input  logic              ps_clk,
    input  logic              ps_rstb,
    axi4_if.master            pl_m_axi_rd,
    input  logic              calib_done,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [23:0]       len_beats,
    input  logic              abort,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              done,
    output logic              rd_err,
    output logic              aborted
);

    dma_state_t        r_state;
    dma_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [23:0]       r_remain;
    logic              r_abort_pend;
    logic              r_rd_err;
    logic              r_aborted;

    logic [8:0]        w_burst;
    logic [ADDR_W-1:0] w_burst_bytes;
    logic              w_start;
    logic              w_ar_hs;
    logic              w_r_hs;
    logic              w_last_of_xfer;
    logic              w_abort_any;
    logic              w_abort_drain;
    logic              w_abort_done;
    logic              w_unused;

    dma_burst_calc #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_calc (
        .i_beat_in_page (r_addr[11:5]),
        .i_remain       (r_remain),
        .o_burst        (w_burst)
    );

    assign w_burst_bytes  = ADDR_W'(w_burst) * ADDR_W'(BYTES_PER_BEAT);
    assign w_start        = (r_state == IDLE) && start;
    assign w_ar_hs        = (r_state == ADDR) && pl_m_axi_rd.arready;
    assign w_r_hs         = (r_state == DATA) && pl_m_axi_rd.rvalid && m_axis_tready;
    assign w_last_of_xfer = (r_remain == 24'd1);
    assign w_abort_any    = r_abort_pend || abort;

    // Abort after the AR is accepted must let the in-flight burst drain.
    assign w_abort_drain  = abort && (w_ar_hs || (r_state == DATA));
    assign w_abort_done   = (abort && (r_state == WAIT_CAL))
                         || (abort && (r_state == ADDR) && !pl_m_axi_rd.arready)
                         || (w_r_hs && pl_m_axi_rd.rlast && w_abort_any);

    always_ff @(posedge ps_clk or negedge ps_rstb) begin
        if (!ps_rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len_beats == 24'd0) begin
                        w_state_nxt = FIN;
                    end else if (!calib_done) begin
                        w_state_nxt = WAIT_CAL;
                    end else begin
                        w_state_nxt = ADDR;
                    end
                end
            end
            WAIT_CAL: begin
                if (abort) begin
                    w_state_nxt = FIN;
                end else if (calib_done) begin
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (pl_m_axi_rd.arready) begin
                    w_state_nxt = DATA;
                end else if (abort) begin
                    w_state_nxt = FIN;
                end
            end
            DATA: begin
                if (w_r_hs && pl_m_axi_rd.rlast) begin
                    w_state_nxt = (w_last_of_xfer || w_abort_any) ? FIN : ADDR;
                end
            end
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ps_clk or negedge ps_rstb) begin
        if (!ps_rstb) begin
            r_addr       <= '0;
            r_remain     <= '0;
            r_abort_pend <= 1'b0;
            r_rd_err     <= 1'b0;
            r_aborted    <= 1'b0;
        end else if (w_start) begin
            r_addr       <= base_addr;
            r_remain     <= len_beats;
            r_abort_pend <= 1'b0;
            r_rd_err     <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_addr <= r_addr + w_burst_bytes;
            end
            if (w_r_hs) begin
                r_remain <= r_remain - 24'd1;
                if (pl_m_axi_rd.rresp != 2'b00) begin
                    r_rd_err <= 1'b1;
                end
            end
            if (w_abort_drain) begin
                r_abort_pend <= 1'b1;
            end
            if (w_abort_done) begin
                r_aborted <= 1'b1;
            end
        end
    end

    assign pl_m_axi_rd.arid    = {ID_W{1'b0}};
    assign pl_m_axi_rd.araddr  = r_addr;
    assign pl_m_axi_rd.arlen   = 8'(w_burst - 9'd1);
    assign pl_m_axi_rd.arsize  = c_AXI_SIZE_32B;
    assign pl_m_axi_rd.arburst = c_AXI_BURST_INCR;
    assign pl_m_axi_rd.arlock  = 1'b0;
    assign pl_m_axi_rd.arcache = c_AXI_CACHE_RD;
    assign pl_m_axi_rd.arprot  = 3'd0;
    assign pl_m_axi_rd.arqos   = 4'd0;
    assign pl_m_axi_rd.arvalid = (r_state == ADDR);
    assign pl_m_axi_rd.rready  = (r_state == DATA) && m_axis_tready;

    assign pl_m_axi_rd.awid    = {ID_W{1'b0}};
    assign pl_m_axi_rd.awaddr  = '0;
    assign pl_m_axi_rd.awlen   = 8'd0;
    assign pl_m_axi_rd.awsize  = 3'd0;
    assign pl_m_axi_rd.awburst = 2'd0;
    assign pl_m_axi_rd.awlock  = 1'b0;
    assign pl_m_axi_rd.awcache = 4'd0;
    assign pl_m_axi_rd.awprot  = 3'd0;
    assign pl_m_axi_rd.awqos   = 4'd0;
    assign pl_m_axi_rd.awvalid = 1'b0;
    assign pl_m_axi_rd.wdata   = '0;
    assign pl_m_axi_rd.wstrb   = '0;
    assign pl_m_axi_rd.wlast   = 1'b0;
    assign pl_m_axi_rd.wvalid  = 1'b0;
    assign pl_m_axi_rd.bready  = 1'b1;

    // Zero-latency pass-through; tlast also closes a burst drained after abort.
    assign m_axis_tdata  = pl_m_axi_rd.rdata;
    assign m_axis_tvalid = (r_state == DATA) && pl_m_axi_rd.rvalid;
    assign m_axis_tlast  = m_axis_tvalid && (w_last_of_xfer || (pl_m_axi_rd.rlast && w_abort_any));

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == FIN);
    assign rd_err  = r_rd_err;
    assign aborted = r_aborted;

    assign w_unused = ^{pl_m_axi_rd.awready, pl_m_axi_rd.wready, pl_m_axi_rd.bid,
                        pl_m_axi_rd.bresp, pl_m_axi_rd.bvalid, pl_m_axi_rd.rid};

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_dma.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr_rd_dma
// Brief    : Self-checking bench: AXI slave memory model plus stream scoreboard.
// Revision : 1.0
// ============================================================================
module tb_ddr_rd_dma;

    localparam int ADDR_W    = 40;
    localparam int DATA_W    = 256;
    localparam int ID_W      = 4;
    localparam int MAX_BURST = 16;

    logic              ps_clk;
    logic              ps_rstb;
    logic              calib_done;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [23:0]       len_beats;
    logic              abort;
    logic [DATA_W-1:0] m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic              busy;
    logic              done;
    logic              rd_err;
    logic              aborted;

    axi4_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

    ddr_rd_dma #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ID_W      (ID_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .ps_clk        (ps_clk),
        .ps_rstb       (ps_rstb),
        .pl_m_axi_rd   (axi),
        .calib_done    (calib_done),
        .start         (start),
        .base_addr     (base_addr),
        .len_beats     (len_beats),
        .abort         (abort),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .rd_err        (rd_err),
        .aborted       (aborted)
    );

    initial ps_clk = 1'b0;
    always #5 ps_clk = ~ps_clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
    } ar_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    typedef struct {
        logic [ADDR_W-1:0]       base;
        int                      len;
        int                      nar;
        logic [2:0][ADDR_W-1:0]  ara;
        logic [2:0][7:0]         arl;
    } vec_t;

    int                checks    = 0;
    int                failures  = 0;
    int                sink_beats = 0;
    logic              rand_mode;
    logic [ADDR_W-1:0] err_addr;
    ar_t               ar_q[$];
    beat_t             beat_q[$];

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return {4{{24'h5A5A00, a[39:32]}, a[31:0] ^ 32'hC3C3_0000}};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // AXI read slave: random arready / rvalid gaps in rand_mode, one error address.
    int                rbeats = 0;
    logic [ADDR_W-1:0] raddr;
    logic              r_taken = 1'b0;
    logic              p_arv = 1'b0;
    logic              p_arr = 1'b0;
    logic [ADDR_W-1:0] p_araddr;
    logic [7:0]        p_arlen;

    initial begin
        ar_t e;
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00;
        axi.rlast = 1'b0; axi.rid = '0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = 2'b00;
        forever begin
            @(negedge ps_clk);
            axi.arready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!axi.rvalid || r_taken) begin
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
                if (rbeats > 0 && (!rand_mode || $urandom_range(0, 3) != 0)) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = pat(raddr);
                    axi.rlast  = (rbeats == 1);
                    axi.rresp  = (raddr == err_addr) ? 2'b10 : 2'b00;
                end
            end
            r_taken = 1'b0;
            #4;
            if (p_arv && !p_arr) begin
                chk("ar_hold", {axi.arvalid, axi.araddr, axi.arlen}, {1'b1, p_araddr, p_arlen});
            end
            p_arv = axi.arvalid; p_arr = axi.arready;
            p_araddr = axi.araddr; p_arlen = axi.arlen;
            if (axi.arvalid && axi.arready) begin
                chk("one_outstanding", rbeats, 0);
                chk("ar_attr", {axi.arid, axi.arsize, axi.arburst, axi.arcache, axi.arlock, axi.arprot, axi.arqos},
                    {4'd0, 3'd5, 2'd1, 4'b0011, 1'b0, 3'd0, 4'd0});
                chk("wr_idle_rready", {axi.awvalid, axi.wvalid, axi.bready, axi.rready}, 4'b0010);
                if (ar_q.size() == 0) begin
                    note_fail("unexpected_ar");
                end else begin
                    e = ar_q.pop_front();
                    chk("araddr", axi.araddr, e.addr);
                    chk("arlen", axi.arlen, e.len);
                end
                rbeats = int'(axi.arlen) + 1;
                raddr  = axi.araddr;
            end
            if (axi.rvalid && axi.rready) begin
                r_taken = 1'b1;
                rbeats--;
                raddr = raddr + ADDR_W'(32);
            end
        end
    end

    // Stream sink and scoreboard.
    initial begin
        beat_t b;
        m_axis_tready = 1'b0;
        forever begin
            @(negedge ps_clk);
            m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (m_axis_tvalid && m_axis_tready) begin
                sink_beats++;
                if (beat_q.size() == 0) begin
                    note_fail("unexpected_beat");
                end else begin
                    b = beat_q.pop_front();
                    chk("tdata", m_axis_tdata, b.data);
                    chk("tlast", m_axis_tlast, b.last);
                end
            end
        end
    end

    task automatic push_ar(input logic [ADDR_W-1:0] a, input logic [7:0] l);
        ar_t e;
        e.addr = a;
        e.len  = l;
        ar_q.push_back(e);
    endtask

    task automatic push_beats(input logic [ADDR_W-1:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = pat(base + ADDR_W'(i * 32));
            b.last = (i == n - 1);
            beat_q.push_back(b);
        end
    endtask

    task automatic kick(input logic [ADDR_W-1:0] base, input int len, input logic with_abort);
        @(negedge ps_clk);
        base_addr = base;
        len_beats = 24'(len);
        start     = 1'b1;
        abort     = with_abort;
        @(negedge ps_clk);
        start     = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic finish_xfer(input int budget, input logic exp_ab, input logic exp_err);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            #4;
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge ps_clk);
        end
        chk("done_seen", ok, 1'b1);
        chk("busy_in_fin", busy, 1'b1);
        chk("aborted", aborted, exp_ab);
        chk("rd_err", rd_err, exp_err);
        chk("beats_pending", beat_q.size(), 0);
        chk("ars_pending", ar_q.size(), 0);
        beat_q.delete();
        ar_q.delete();
        @(negedge ps_clk);
        #4;
        chk("idle_after_fin", {busy, done}, 2'b00);
        @(negedge ps_clk);
    endtask

    vec_t vecs[6];

    initial begin
        bit seen;
        int base_cnt;
        ps_rstb = 1'b0; calib_done = 1'b1; start = 1'b0; abort = 1'b0;
        base_addr = '0; len_beats = '0; rand_mode = 1'b0; err_addr = '1;

        vecs[0] = '{base: 40'h0,          len: 40, nar: 3, ara: {40'h400, 40'h200, 40'h0},  arl: {8'd7, 8'd15, 8'd15}};
        vecs[1] = '{base: 40'hFC0,        len: 4,  nar: 2, ara: {40'h0, 40'h1000, 40'hFC0}, arl: {8'd0, 8'd1, 8'd1}};
        vecs[2] = '{base: 40'h1F00,       len: 20, nar: 2, ara: {40'h0, 40'h2000, 40'h1F00}, arl: {8'd0, 8'd11, 8'd7}};
        vecs[3] = '{base: 40'h40,         len: 1,  nar: 1, ara: {40'h0, 40'h0, 40'h40},     arl: {8'd0, 8'd0, 8'd0}};
        vecs[4] = '{base: 40'h12_3456_7E0, len: 16, nar: 1, ara: {40'h0, 40'h0, 40'h12_3456_7E0}, arl: {8'd0, 8'd0, 8'd15}};
        vecs[5] = '{base: 40'hE00,        len: 24, nar: 2, ara: {40'h0, 40'h1000, 40'hE00}, arl: {8'd0, 8'd7, 8'd15}};

        @(negedge ps_clk);
        #4;
        chk("reset_outputs", {axi.arvalid, axi.rready, m_axis_tvalid, m_axis_tlast, busy, done, rd_err, aborted}, 8'h00);
        @(negedge ps_clk);
        ps_rstb = 1'b1;
        repeat (2) @(negedge ps_clk);

        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].nar; k++) push_ar(vecs[v].ara[k], vecs[v].arl[k]);
            push_beats(vecs[v].base, vecs[v].len);
            kick(vecs[v].base, vecs[v].len, 1'b0);
            finish_xfer(3000, 1'b0, 1'b0);
        end

        // Zero-length transfer: FIN straight away, no AR.
        kick(40'h100, 0, 1'b0);
        #4;
        chk("len0_done", {done, busy}, 2'b11);
        @(negedge ps_clk);
        #4;
        chk("len0_idle", {done, busy}, 2'b00);
        @(negedge ps_clk);

        // Calibration held low for 50 cycles.
        calib_done = 1'b0;
        push_ar(40'h2000, 8'd15);
        push_beats(40'h2000, 16);
        kick(40'h2000, 16, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            #4;
            if (axi.arvalid) seen = 1'b1;
            @(negedge ps_clk);
        end
        chk("no_ar_before_cal", seen, 1'b0);
        #4;
        chk("busy_wait_cal", busy, 1'b1);
        @(negedge ps_clk);
        calib_done = 1'b1;
        finish_xfer(3000, 1'b0, 1'b0);

        // Abort while waiting for calibration.
        calib_done = 1'b0;
        kick(40'h0, 8, 1'b0);
        abort = 1'b1;
        @(negedge ps_clk);
        abort = 1'b0;
        finish_xfer(100, 1'b1, 1'b0);
        calib_done = 1'b1;

        // Abort mid-DATA of a 64-beat transfer: second burst drains, then stop.
        push_ar(40'h0, 8'd15);
        push_ar(40'h200, 8'd15);
        push_beats(40'h0, 32);
        base_cnt = sink_beats;
        kick(40'h0, 64, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            #4;
            if (sink_beats >= base_cnt + 20) begin
                seen = 1'b1;
                break;
            end
            @(negedge ps_clk);
        end
        chk("abort_point_reached", seen, 1'b1);
        @(negedge ps_clk);
        abort = 1'b1;
        @(negedge ps_clk);
        abort = 1'b0;
        finish_xfer(3000, 1'b1, 1'b0);

        // Abort coincident with start in IDLE is a plain start.
        push_ar(40'h300, 8'd1);
        push_beats(40'h300, 2);
        kick(40'h300, 2, 1'b1);
        finish_xfer(3000, 1'b0, 1'b0);

        // Slave error on one beat with random stalls everywhere.
        rand_mode = 1'b1;
        err_addr  = 40'h820;
        push_ar(40'h780, 8'd15);
        push_ar(40'h980, 8'd7);
        push_beats(40'h780, 24);
        kick(40'h780, 24, 1'b0);
        finish_xfer(3000, 1'b0, 1'b1);
        #4;
        chk("rd_err_sticky", rd_err, 1'b1);
        @(negedge ps_clk);
        rand_mode = 1'b0;
        err_addr  = '1;
        repeat (2) @(negedge ps_clk);

        push_ar(40'h0, 8'd1);
        push_beats(40'h0, 2);
        kick(40'h0, 2, 1'b0);
        #4;
        chk("rd_err_cleared", {rd_err, aborted}, 2'b00);
        @(negedge ps_clk);
        finish_xfer(3000, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
